// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: forwarding source codes and the
// Tnew value used by writers that never produce a result in-pipeline.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    localparam int FWD_LEN = 2;
    localparam int T_NEVER = 6;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Resolves one source operand against the E/M/W writer entries: picks the
// youngest matching writer, then derives the stall request and forwarding select.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int T_W    = 4
) (
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [T_W-1:0]    src_tuse,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [T_W-1:0]    e_tnew,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [T_W-1:0]    m_tnew,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [T_W-1:0]    w_tnew,
    output logic              stall_req,
    output logic [1:0]        fwd_sel
);

    // Younger stages are tested first so an older writer is never seen when shadowed.
    always_comb begin
        stall_req = 1'b0;
        fwd_sel   = FWD_RF;
        if (src_addr != '0) begin
            if (src_addr == e_addr) begin
                stall_req = (e_tnew > src_tuse);
                fwd_sel   = (e_tnew == '0) ? FWD_EX : FWD_RF;
            end else if (src_addr == m_addr) begin
                stall_req = (m_tnew > src_tuse);
                fwd_sel   = (m_tnew == '0) ? FWD_MEM : FWD_RF;
            end else if (src_addr == w_addr) begin
                fwd_sel   = (w_tnew == '0) ? FWD_WB : FWD_RF;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard beside the D/E register: tracks E/M/W writers,
// raises stall and drives ID/EX forwarding selects. Optional counters: HAZARD_STATS_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int T_W    = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [T_W-1:0]    id_tuse1,
    input  logic [ADDR_W-1:0] id_addr1,
    input  logic [T_W-1:0]    id_tuse2,
    input  logic [ADDR_W-1:0] id_addr2,
    input  logic [T_W-1:0]    id_tnew,
    input  logic [ADDR_W-1:0] id_addr_new,
    output logic              stall,
    output logic [1:0]        fwd_id_rs,
    output logic [1:0]        fwd_id_rt,
    output logic [1:0]        fwd_ex_rs,
    output logic [1:0]        fwd_ex_rt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  issue_cnt
);

    function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] x);
        return (x == '0) ? '0 : x - T_W'(1);
    endfunction

    logic [ADDR_W-1:0] e_addr_q, e_addr_d;
    logic [T_W-1:0]    e_tnew_q, e_tnew_d;
    logic [ADDR_W-1:0] e_src1_q, e_src1_d;
    logic [ADDR_W-1:0] e_src2_q, e_src2_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [T_W-1:0]    m_tnew_q, m_tnew_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;

    logic id_rs_stall, id_rt_stall;
    logic ex_rs_stall_unused, ex_rt_stall_unused;

    hazard_match #(.ADDR_W(ADDR_W), .T_W(T_W)) u_id_rs (
        .src_addr (id_addr1),
        .src_tuse (id_tuse1),
        .e_addr   (e_addr_q),
        .e_tnew   (e_tnew_q),
        .m_addr   (m_addr_q),
        .m_tnew   (m_tnew_q),
        .w_addr   (w_addr_q),
        .w_tnew   ('0),
        .stall_req(id_rs_stall),
        .fwd_sel  (fwd_id_rs)
    );

    hazard_match #(.ADDR_W(ADDR_W), .T_W(T_W)) u_id_rt (
        .src_addr (id_addr2),
        .src_tuse (id_tuse2),
        .e_addr   (e_addr_q),
        .e_tnew   (e_tnew_q),
        .m_addr   (m_addr_q),
        .m_tnew   (m_tnew_q),
        .w_addr   (w_addr_q),
        .w_tnew   ('0),
        .stall_req(id_rt_stall),
        .fwd_sel  (fwd_id_rt)
    );

    // EX operands only look downstream, so the E entry is presented as empty.
    hazard_match #(.ADDR_W(ADDR_W), .T_W(T_W)) u_ex_rs (
        .src_addr (e_src1_q),
        .src_tuse ('0),
        .e_addr   ('0),
        .e_tnew   ('0),
        .m_addr   (m_addr_q),
        .m_tnew   (m_tnew_q),
        .w_addr   (w_addr_q),
        .w_tnew   ('0),
        .stall_req(ex_rs_stall_unused),
        .fwd_sel  (fwd_ex_rs)
    );

    hazard_match #(.ADDR_W(ADDR_W), .T_W(T_W)) u_ex_rt (
        .src_addr (e_src2_q),
        .src_tuse ('0),
        .e_addr   ('0),
        .e_tnew   ('0),
        .m_addr   (m_addr_q),
        .m_tnew   (m_tnew_q),
        .w_addr   (w_addr_q),
        .w_tnew   ('0),
        .stall_req(ex_rt_stall_unused),
        .fwd_sel  (fwd_ex_rt)
    );

    assign stall = id_rs_stall | id_rt_stall;

    always_comb begin
        m_addr_d = e_addr_q;
        m_tnew_d = dec_sat(e_tnew_q);
        w_addr_d = m_addr_q;
        if (stall) begin
            e_addr_d = '0;
            e_tnew_d = '0;
            e_src1_d = '0;
            e_src2_d = '0;
        end else begin
            e_addr_d = id_addr_new;
            e_tnew_d = dec_sat(id_tnew);
            e_src1_d = id_addr1;
            e_src2_d = id_addr2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_addr_q <= '0;
            e_tnew_q <= '0;
            e_src1_q <= '0;
            e_src2_q <= '0;
            m_addr_q <= '0;
            m_tnew_q <= '0;
            w_addr_q <= '0;
        end else begin
            e_addr_q <= e_addr_d;
            e_tnew_q <= e_tnew_d;
            e_src1_q <= e_src1_d;
            e_src2_q <= e_src2_d;
            m_addr_q <= m_addr_d;
            m_tnew_q <= m_tnew_d;
            w_addr_q <= w_addr_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    // Counters hold at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        issue_cnt_d = issue_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!stall && (issue_cnt_q != '1)) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign issue_cnt = issue_cnt_q;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign issue_cnt = {CNT_W{1'b0}};
`endif

endmodule
